vector_sequencer: RTL

- Upstream feeder for the Bresenham line stepper.
- Buffers a list of endpoints written by the host/command parser in a small FIFO.
- Issues each endpoint to the line stepper as a one-cycle strobe, but only once the stepper reports ready.
- Holds a programmable settle dwell at every endpoint and drives the beam-enable (bright) output for the segment in flight.

---
 rtl/vector_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/vector_sequencer.sv
// Endpoint FIFO feeding the line stepper: one strobe per endpoint, a settle dwell at each endpoint, beam enable per segment.
// Strobe comes 1 cycle after the head is seen with line_ready=1; overfull writes are dropped and flagged in a sticky bit.
module vector_sequencer #(
    parameter int BITS       = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int DWELL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_strobe,
    input  logic [BITS-1:0]       wr_x,
    input  logic [BITS-1:0]       wr_y,
    input  logic                  wr_bright,
    input  logic [DWELL_BITS-1:0] dwell,
    output logic                  full,
    output logic                  overflow,
    output logic                  idle,
    input  logic                  line_ready,
    output logic                  line_strobe,
    output logic [BITS-1:0]       line_x,
    output logic [BITS-1:0]       line_y,
    output logic                  bright
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_MOVE,
        S_DWELL
    } state_t;

    state_t state, state_nxt;

    logic [BITS-1:0]       mem_x [DEPTH];
    logic [BITS-1:0]       mem_y [DEPTH];
    logic                  mem_b [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic                  empty, push, pop, start;

    assign empty       = (count == '0);
    assign full        = (count == FULL_COUNT);
    assign idle        = (state == S_IDLE) && empty;
    assign push        = wr_strobe && !full;
    assign pop         = (state == S_ISSUE);
    assign line_strobe = (state == S_ISSUE);
    assign start       = (state == S_IDLE) && (state_nxt == S_ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!empty && line_ready) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_LOAD;
            // The stepper's ready still reflects the old destination here.
            S_LOAD:  state_nxt = S_MOVE;
            S_MOVE:  if (line_ready) state_nxt = S_DWELL;
            S_DWELL: if (dwell_cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= wr_x;
            mem_y[wr_ptr] <= wr_y;
            mem_b[wr_ptr] <= wr_bright;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            line_x    <= '0;
            line_y    <= '0;
            bright    <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_strobe && full) overflow <= 1'b1;
            // Head is stable between IDLE and ISSUE, so the outputs are valid for the whole strobe cycle.
            if (start) begin
                line_x    <= mem_x[rd_ptr];
                line_y    <= mem_y[rd_ptr];
                bright    <= mem_b[rd_ptr];
                dwell_cnt <= dwell;
            end
            if (state == S_DWELL) begin
                if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
                else if (empty)      bright    <= 1'b0;
            end
        end
    end

endmodule
